// File: rtl/wb_relay_sequencer.sv
// Wishbone B3 relay output register with per-channel minimum-on/minimum-off hold timers and load shed.
// Define RELAY_STAGGER_EN to allow at most one OFF->ON transition per tick window (lowest index first).
module wb_relay_sequencer #(
  parameter int unsigned N_CH     = 8,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned TIMER_W  = 16,
  parameter int unsigned MIN_ON   = 180,
  parameter int unsigned MIN_OFF  = 300
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        wb_adr,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic [3:0]        wb_sel,
  input  logic              wb_we,
  input  logic              wb_stb,
  input  logic              wb_cyc,
  output logic              wb_ack,
  input  logic [N_CH-1:0]   shed,
  output logic [N_CH-1:0]   relay_out
);

  localparam int unsigned PS_W = $clog2(PRESCALE);
  localparam logic [TIMER_W-1:0] MIN_ON_T  = TIMER_W'(MIN_ON);
  localparam logic [TIMER_W-1:0] MIN_OFF_T = TIMER_W'(MIN_OFF);

  typedef enum logic [1:0] {
    OFF_HOLD,
    OFF,
    ON_HOLD,
    ON
  } ch_state_t;

  logic [PS_W-1:0]    ps_cnt;
  logic               tick;

  logic [N_CH-1:0]    req_q;
  logic [N_CH-1:0]    req_wr;
  logic [N_CH-1:0]    hold_vec;
  logic [N_CH-1:0]    relay_d;
  logic               acc;
  logic               req_write;
  logic [31:0]        lane_mask;
  logic [31:0]        req_wide;
  logic [31:0]        rd_data;
  logic               unused_bits;

  ch_state_t          state_q [N_CH];
  ch_state_t          state_d [N_CH];
  logic [TIMER_W-1:0] timer_q [N_CH];
  logic [TIMER_W-1:0] timer_d [N_CH];

`ifdef RELAY_STAGGER_EN
  logic               stagger_q;
  logic               stagger_d;
`endif

  // Prescaler: tick on the cycle the count sits at PRESCALE-1
  assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  // Bus front end
  assign acc       = wb_stb & wb_cyc & ~wb_ack;
  assign req_write = acc & wb_we & (wb_adr == 2'd0);

  always_comb begin
    lane_mask = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      lane_mask[b*8 +: 8] = {8{wb_sel[b]}};
    end
    req_wide = (32'(req_q) & ~lane_mask) | (wb_dat_i & lane_mask);
    req_wr   = req_wide[N_CH-1:0];
  end

  assign unused_bits = ^req_wide;

  always_comb begin
    hold_vec = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      hold_vec[i] = (timer_q[i] != '0);
    end
  end

  always_comb begin
    rd_data = '0;
    case (wb_adr)
      2'd0:    rd_data = 32'(req_q);
      2'd1:    rd_data = 32'(relay_out);
      2'd2:    rd_data = 32'(hold_vec);
      default: rd_data = 32'(req_q ^ relay_out);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
      req_q    <= '0;
    end else begin
      wb_ack <= acc;
      if (acc && !wb_we) begin
        wb_dat_o <= rd_data;
      end
      if (req_write) begin
        req_q <= req_wr;
      end
    end
  end

  // Channel FSMs: hold expiry and the follow-on transition are taken on the same edge
  always_comb begin
    logic expired;
    logic turn_on;
    logic turn_off;
    logic blocked;
    logic any_on;
    relay_d  = relay_out;
    expired  = 1'b0;
    turn_on  = 1'b0;
    turn_off = 1'b0;
    any_on   = 1'b0;
`ifdef RELAY_STAGGER_EN
    blocked  = stagger_q;
    stagger_d = stagger_q;
`else
    blocked  = 1'b0;
`endif
    for (int unsigned i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      expired    = (timer_q[i] == '0);
      turn_on    = 1'b0;
      turn_off   = 1'b0;
      if (tick && !expired) begin
        timer_d[i] = timer_q[i] - TIMER_W'(1);
      end
      case (state_q[i])
        OFF_HOLD, OFF: begin
          if (expired || state_q[i] == OFF) begin
            state_d[i] = OFF;
            turn_on    = req_q[i] & ~shed[i] & ~blocked;
          end
        end
        ON_HOLD: begin
          if (shed[i] || (expired && !req_q[i])) begin
            turn_off = 1'b1;
          end else if (expired) begin
            state_d[i] = ON;
          end
        end
        ON: begin
          turn_off = shed[i] | ~req_q[i];
        end
        default: state_d[i] = OFF_HOLD;
      endcase
      if (turn_on) begin
        state_d[i] = ON_HOLD;
        timer_d[i] = MIN_ON_T;
        relay_d[i] = 1'b1;
        any_on     = 1'b1;
`ifdef RELAY_STAGGER_EN
        blocked    = 1'b1;
`endif
      end
      if (turn_off) begin
        state_d[i] = OFF_HOLD;
        timer_d[i] = MIN_OFF_T;
        relay_d[i] = 1'b0;
      end
    end
`ifdef RELAY_STAGGER_EN
    // A turn-on on a tick edge still closes the window it opens
    stagger_d = any_on | (stagger_q & ~tick);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i] <= OFF_HOLD;
        timer_q[i] <= MIN_OFF_T;
      end
      relay_out <= '0;
`ifdef RELAY_STAGGER_EN
      stagger_q <= 1'b0;
`endif
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      relay_out <= relay_d;
`ifdef RELAY_STAGGER_EN
      stagger_q <= stagger_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_relay_sequencer.sv
// Directed bench for wb_relay_sequencer: hold timing, shed override, bus handshake, async reset, staggering.
module tb_wb_relay_sequencer;

  localparam int unsigned N = 4;
`ifdef RELAY_STAGGER_EN
  localparam bit STAG = 1'b1;
`else
  localparam bit STAG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    wb_adr;
  logic [31:0]   wb_dat_i;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel;
  logic          wb_we;
  logic          wb_stb;
  logic          wb_cyc;
  logic          wb_ack;
  logic [N-1:0]  shed;
  logic [N-1:0]  relay_out;

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  int unsigned   edge_n = 0;
  logic [31:0]   rd;

  always #5 clk = ~clk;

  wb_relay_sequencer #(
    .N_CH     (N),
    .PRESCALE (4),
    .TIMER_W  (8),
    .MIN_ON   (3),
    .MIN_OFF  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_adr    (wb_adr),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_sel    (wb_sel),
    .wb_we     (wb_we),
    .wb_stb    (wb_stb),
    .wb_cyc    (wb_cyc),
    .wb_ack    (wb_ack),
    .shed      (shed),
    .relay_out (relay_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  task automatic run_to(input int unsigned target);
    if (target > edge_n) step(target - edge_n);
  endtask

  task automatic bus_write(input logic [1:0] adr, input logic [31:0] data, input logic [3:0] sel);
    wb_adr = adr; wb_dat_i = data; wb_sel = sel; wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
    step(1);
    check("wr_ack", 32'(wb_ack), 32'd1);
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    step(1);
    check("wr_ack_drop", 32'(wb_ack), 32'd0);
  endtask

  task automatic bus_read(input logic [1:0] adr, output logic [31:0] data);
    wb_adr = adr; wb_sel = 4'hF; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
    step(1);
    check("rd_ack", 32'(wb_ack), 32'd1);
    data = wb_dat_o;
    wb_stb = 1'b0; wb_cyc = 1'b0;
    step(1);
    check("rd_ack_drop", 32'(wb_ack), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; wb_adr = '0; wb_dat_i = '0; wb_sel = '0;
    wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0; shed = '0;
    step(3);
    check("rst_relay", 32'(relay_out), 32'h0);
    check("rst_ack",   32'(wb_ack),    32'h0);
    check("rst_dat",   wb_dat_o,       32'h0);

    // Power-up minimum-off: ticks land on edges 4, 8, 12, ...
    rst_n = 1'b1; edge_n = 0;
    bus_write(2'd0, 32'h1, 4'hF);
    bus_read(2'd2, rd);  check("pwr_hold", rd, 32'hF);
    check("pwr_relay_e4", 32'(relay_out), 32'h0);
    bus_read(2'd0, rd);  check("pwr_req", rd, 32'h1);
    bus_read(2'd3, rd);  check("pwr_pend", rd, 32'h1);
    check("pwr_relay_e8", 32'(relay_out), 32'h0);
    step(1);
    check("pwr_rise_e9", 32'(relay_out), 32'h1);

    // Minimum-on: on at edge 9, timer 3 expires at tick 20, falls at 21
    bus_write(2'd0, 32'h0, 4'hF);
    bus_read(2'd3, rd);  check("mon_pend", rd, 32'h1);
    bus_read(2'd1, rd);  check("mon_state", rd, 32'h1);
    run_to(20);          check("mon_still_on", 32'(relay_out), 32'h1);
    step(1);             check("mon_fall", 32'(relay_out), 32'h0);

    // Minimum-off: off at 21, timer 2 expires at tick 28, rises at 29
    bus_write(2'd0, 32'h1, 4'hF);
    bus_read(2'd1, rd);  check("moff_state", rd, 32'h0);
    run_to(28);          check("moff_still_off", 32'(relay_out), 32'h0);
    step(1);             check("moff_rise", 32'(relay_out), 32'h1);
    bus_read(2'd2, rd);  check("onhold_hold", rd, 32'h1);

    // Shed override of channel 2 during ON_HOLD
    run_to(32);
    bus_write(2'd0, 32'h5, 4'hF);
    check("shed_pre", 32'(relay_out), 32'h5);
    shed = 4'h4;
    step(1);
    shed = 4'h0;
    check("shed_drop", 32'(relay_out), 32'h1);
    bus_read(2'd0, rd);  check("shed_req_kept", rd, 32'h5);
    run_to(40);          check("shed_min_off", 32'(relay_out), 32'h1);
    step(1);             check("shed_reenable", 32'(relay_out), 32'h5);

    // Shed held high keeps channel 0 off past its hold
    shed = 4'h1;
    step(1);             check("shed_hold_drop", 32'(relay_out), 32'h4);
    bus_read(2'd0, rd);  check("shed_hold_req", rd, 32'h5);
    run_to(52);          check("shed_hold_off", 32'(relay_out), 32'h4);
    shed = 4'h0;
    step(1);             check("shed_release", 32'(relay_out), 32'h5);

    // Byte-lane gating, read-only writes, aborted cycle
    bus_write(2'd0, 32'hFFFF_FF0A, 4'b0001);
    bus_read(2'd0, rd);  check("lane0_req", rd, 32'hA);
    bus_write(2'd1, 32'h3, 4'hF);
    bus_read(2'd0, rd);  check("ro_write_ignored", rd, 32'hA);
    bus_write(2'd0, 32'h0000_0F00, 4'b0010);
    bus_read(2'd0, rd);  check("lane1_no_effect", rd, 32'hA);
    wb_adr = 2'd0; wb_dat_i = 32'h5; wb_sel = 4'hF; wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
    #3;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    step(1);             check("abort_no_ack", 32'(wb_ack), 32'h0);
    bus_read(2'd0, rd);  check("abort_req", rd, 32'hA);
    check("pre_reset_relay", 32'(relay_out), 32'hA);

    // Asynchronous reset between edges
    rst_n = 1'b0;
    #1;
    check("async_relay", 32'(relay_out), 32'h0);
    check("async_dat",   wb_dat_o,       32'h0);
    step(2);

    // All four channels requested together after reset
    rst_n = 1'b1; edge_n = 0;
    bus_write(2'd0, 32'hF, 4'hF);
    run_to(8);           check("all_wait", 32'(relay_out), 32'h0);
    step(1);             check("all_e9",  32'(relay_out), STAG ? 32'h1 : 32'hF);
    run_to(13);          check("all_e13", 32'(relay_out), STAG ? 32'h3 : 32'hF);
    run_to(17);          check("all_e17", 32'(relay_out), STAG ? 32'h7 : 32'hF);
    run_to(21);          check("all_e21", 32'(relay_out), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
